// File: rtl/lutram_access_arbiter.sv
// lutram_access_arbiter: round-robin front end for one single-port LUTRAM.
// After reset it sweeps every set to zero, then grants one client per cycle
// and routes read data back to the client that issued the read.

`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

module lutram_access_arbiter #(
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int NUM_SET                    = 64,
  parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
  parameter int WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / `BYTE_LEN_IN_BITS,
  parameter int NUM_REQUESTER              = 2,
  parameter int READ_LATENCY               = 1
) (
  input  logic                                             clk_in,
  input  logic                                             reset_in,
  input  logic [NUM_REQUESTER-1:0]                         request_valid_in,
  output logic [NUM_REQUESTER-1:0]                         request_ready_out,
  input  logic [NUM_REQUESTER*WRITE_MASK_LEN-1:0]          request_write_mask_in,
  input  logic [NUM_REQUESTER*SET_PTR_WIDTH_IN_BITS-1:0]   request_addr_in,
  input  logic [NUM_REQUESTER*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_data_in,
  output logic [NUM_REQUESTER-1:0]                         response_valid_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]            response_data_out,
  output logic                                             init_done_out,
  output logic                                             access_en_out,
  output logic [WRITE_MASK_LEN-1:0]                        write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]                 access_set_addr_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]            write_entry_out,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]            read_entry_in
);

  localparam int ID_W = (NUM_REQUESTER > 1) ? $clog2(NUM_REQUESTER) : 1;
  localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQUESTER - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  state_t                           state_r;
  state_t                           state_next_s;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] clear_ptr_r;
  logic [ID_W-1:0]                  prio_r;
  logic [READ_LATENCY-1:0]          pipe_vld_r;
  logic [ID_W-1:0]                  pipe_id_r [READ_LATENCY];

  logic                             found_s;
  logic [ID_W-1:0]                  winner_s;
  logic [WRITE_MASK_LEN-1:0]        win_mask_s;
  logic                             grant_s;
  logic                             is_read_s;

  // Round-robin scan: first valid client at or after the priority pointer.
  always_comb begin
    logic [ID_W:0] sum_v;
    sum_v    = {(ID_W+1){1'b0}};
    found_s  = 1'b0;
    winner_s = {ID_W{1'b0}};
    for (int k = 0; k < NUM_REQUESTER; k++) begin
      sum_v = {1'b0, prio_r} + (ID_W+1)'(k);
      if (sum_v >= (ID_W+1)'(NUM_REQUESTER)) begin
        sum_v = sum_v - (ID_W+1)'(NUM_REQUESTER);
      end else begin
        sum_v = sum_v;
      end
      if (!found_s && request_valid_in[sum_v[ID_W-1:0]]) begin
        found_s  = 1'b1;
        winner_s = sum_v[ID_W-1:0];
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign win_mask_s = request_write_mask_in[winner_s*WRITE_MASK_LEN +: WRITE_MASK_LEN];
  assign grant_s    = (state_r == ST_SERVE) && found_s;
  assign is_read_s  = grant_s && (win_mask_s == {WRITE_MASK_LEN{1'b0}});

  // Next state and LUTRAM/grant drive; everything drops while reset is low.
  always_comb begin
    state_next_s        = state_r;
    request_ready_out   = {NUM_REQUESTER{1'b0}};
    init_done_out       = 1'b0;
    access_en_out       = 1'b0;
    write_en_out        = {WRITE_MASK_LEN{1'b0}};
    access_set_addr_out = {SET_PTR_WIDTH_IN_BITS{1'b0}};
    write_entry_out     = {SINGLE_ENTRY_WIDTH_IN_BITS{1'b0}};
    if (!reset_in) begin
      state_next_s = ST_CLEAR;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          access_en_out       = 1'b1;
          write_en_out        = {WRITE_MASK_LEN{1'b1}};
          access_set_addr_out = clear_ptr_r;
          if (clear_ptr_r == LAST_SET) begin
            state_next_s = ST_SERVE;
          end else begin
            state_next_s = ST_CLEAR;
          end
        end
        ST_SERVE: begin
          init_done_out = 1'b1;
          if (found_s) begin
            request_ready_out[winner_s] = 1'b1;
            access_en_out       = 1'b1;
            write_en_out        = win_mask_s;
            access_set_addr_out = request_addr_in[winner_s*SET_PTR_WIDTH_IN_BITS +: SET_PTR_WIDTH_IN_BITS];
            write_entry_out     = request_data_in[winner_s*SINGLE_ENTRY_WIDTH_IN_BITS +: SINGLE_ENTRY_WIDTH_IN_BITS];
          end else begin
            access_en_out = 1'b0;
          end
        end
        default: begin
          state_next_s = ST_CLEAR;
        end
      endcase
    end
  end

  // State, clear pointer, priority pointer and read-return pipeline.
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_r     <= ST_CLEAR;
      clear_ptr_r <= {SET_PTR_WIDTH_IN_BITS{1'b0}};
      prio_r      <= {ID_W{1'b0}};
      pipe_vld_r  <= {READ_LATENCY{1'b0}};
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_id_r[i] <= {ID_W{1'b0}};
      end
    end else begin
      state_r <= state_next_s;
      // The pointer parks on the last set so the sweep never repeats.
      if ((state_r == ST_CLEAR) && (clear_ptr_r != LAST_SET)) begin
        clear_ptr_r <= clear_ptr_r + SET_PTR_WIDTH_IN_BITS'(1);
      end else begin
        clear_ptr_r <= clear_ptr_r;
      end
      if (grant_s) begin
        if (winner_s == LAST_ID) begin
          prio_r <= {ID_W{1'b0}};
        end else begin
          prio_r <= winner_s + ID_W'(1);
        end
      end else begin
        prio_r <= prio_r;
      end
      pipe_vld_r[0] <= is_read_s;
      pipe_id_r[0]  <= winner_s;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        pipe_id_r[i]  <= pipe_id_r[i-1];
      end
    end
  end

  // Read return: strobe the issuing client as its entry leaves the pipeline.
  always_comb begin
    response_valid_out = {NUM_REQUESTER{1'b0}};
    response_data_out  = {SINGLE_ENTRY_WIDTH_IN_BITS{1'b0}};
    if (reset_in && pipe_vld_r[READ_LATENCY-1]) begin
      response_valid_out[pipe_id_r[READ_LATENCY-1]] = 1'b1;
      response_data_out = read_entry_in;
    end else begin
      response_data_out = {SINGLE_ENTRY_WIDTH_IN_BITS{1'b0}};
    end
  end

endmodule
